approx_carry_pred_adder_pipe: RTL
=================================

APPROX_CARRY_PRED_ADDER_PIPE -- requirements
Module: approx_carry_pred_adder_pipe

Interface
Parameters (name, default, meaning):
REQ-001 The block SHALL have parameter W, default 16: operand width; legal range 4..64.
REQ-002 The block SHALL have parameter L, default 8: width of the approximate low segment; legal range 3..W-1.
REQ-003 The block SHALL have parameter T, default 3: number of forced low bits; legal range 0..L-2.
REQ-004 The block SHALL have parameter CW, default 16: statistics counter width.
Ports (name, direction, width, meaning):
REQ-005 The block SHALL have port clk, input, 1: single clock; all state on the rising edge.
REQ-006 The block SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-007 The block SHALL have ports in_valid (input, 1) and in_ready (output, 1): input handshake.
REQ-008 The block SHALL have ports in_a and in_b, input, W each: operands.
REQ-009 The block SHALL have port in_mode, input, 1: 0 selects approximate addition, 1 selects exact addition.
REQ-010 The block SHALL have ports out_valid (output, 1) and out_ready (input, 1): output handshake.
REQ-011 The block SHALL have port out_sum, output, W+1: result.
REQ-012 The block SHALL have port out_err, output, 1: 1 when out_sum differs from the exact in_a+in_b.
REQ-013 The block SHALL have port stat_clr, input, 1: synchronous clear of both statistics counters.
REQ-014 The block SHALL have ports txn_cnt and err_cnt, output, CW each: delivered-transaction count and erroneous-transaction count.

Function
REQ-015 Approximate low segment: ripple bits T..L-2 with carry-in 0, giving sums sb[i] and top carry ct; p = a[L-1]^b[L-1]; c = p & ct.
REQ-016 Approximate low outputs: s[L-1] = ct|p; s[i] = sb[i] & ~c for T<=i<=L-2; s[i] = ~c for i<T.
REQ-017 Approximate low carry-out SHALL be (a[L-1]&b[L-1]) | c, feeding an exact ripple add of bits W-1..L that produces s[W-1:L] and s[W].
REQ-018 With in_mode=1, out_sum SHALL equal the exact zero-extended in_a+in_b and out_err SHALL be 0.
REQ-019 out_err SHALL compare the approximate result against the exact sum of the same operands, computed in parallel.
REQ-020 Pipeline: stage 1 registers operands and mode; stage 2 registers out_sum and out_err; latency is 2 cycles from input handshake to out_valid when unstalled.
REQ-021 Stage 2 advances when !s2_valid | out_ready; stage 1 advances when !s1_valid | stage-2 advance; in_ready = !s1_valid | stage-2 advance, with no combinational path from in_valid to in_ready.
REQ-022 Full-throughput operation SHALL deliver one result per cycle with out_ready held 1; no transaction is dropped or duplicated under any valid/ready pattern.
REQ-023 While out_valid=1 and out_ready=0, out_sum and out_err SHALL hold stable.
REQ-024 Each output handshake (out_valid&out_ready) SHALL increment txn_cnt, and also err_cnt when out_err=1; both saturate at all-ones and never wrap.
REQ-025 stat_clr SHALL zero both counters next cycle and take priority over a simultaneous increment; that transaction is not counted.
REQ-026 Input data is accepted only on in_valid&in_ready; operand values on other cycles have no effect.

Reset
REQ-027 rst_n low SHALL immediately clear s1_valid, s2_valid, out_valid, txn_cnt, err_cnt, out_sum and out_err to 0, regardless of clk.
REQ-028 in_ready SHALL read 1 during and after reset; in-flight transactions are discarded and not counted.
REQ-029 The first input handshake is possible on the first rising edge after rst_n deasserts.

Verification
REQ-030 Defaults, mode 0, in_a=0x00FF, in_b=0x0001 -> out_sum=0x000FF, out_err=1, 2 cycles after accept.
REQ-031 Mode 0, in_a=0x00C8, in_b=0x0048 (c=1 path) -> out_sum=0x00180, out_err=1; then in_a=0x0078, in_b=0x0008 -> out_sum=0x00087, out_err=1.
REQ-032 Mode 1, in_a=0xFFFF, in_b=0x0001 -> out_sum=0x10000, out_err=0; random mode-1 stream checks out_sum against the exact sum.
REQ-033 Random in_valid/out_ready toggling over 10k transactions -> in-order, lossless results matching a reference model; txn_cnt equals handshake count.
REQ-034 CW=4, 20 erroneous transactions -> both counters stick at 0xF; stat_clr asserted with a handshake in the same cycle -> both counters read 0.
REQ-035 rst_n pulsed low mid-stream with 2 transactions in flight -> out_valid=0 asynchronously, counters=0, in_ready=1, and no stale result emerges afterwards.

Source files
------------

// File: rtl/approx_carry_pred_adder_pipe.sv
// ---------------------------------------------------------------------------
// approx_carry_pred_adder_pipe
//
// Two-stage pipelined adder with a selectable approximate low segment.
//
// In approximate mode (in_mode=0):
//   - Bits T..L-2 are added with a short ripple that starts with a carry-in
//     of 0.
//   - Bit L-1 predicts the segment carry.
//   - The T lowest bits are forced.
//   - The upper bits W-1..L are added exactly, using the predicted carry.
// In exact mode (in_mode=1) the result is the plain zero-extended sum.
// out_err flags a result that differs from the exact sum.
//
// Handshake: a transfer happens on a port in any cycle where both valid and
// ready are high at the rising clock edge. A producer holding valid=1 while
// ready=0 keeps its data stable. in_ready depends only on pipeline state and
// out_ready. It never depends on in_valid.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid / in_ready   input handshake
//   in_a, in_b [W-1:0]    operands
//   in_mode               0 = approximate, 1 = exact
//   out_valid / out_ready output handshake
//   out_sum [W:0]         result
//   out_err               result differs from exact in_a+in_b
//   stat_clr              synchronous clear of both statistics counters
//   txn_cnt, err_cnt      saturating delivered / erroneous transaction counts
// ---------------------------------------------------------------------------
module approx_carry_pred_adder_pipe #(
    parameter int W  = 16,
    parameter int L  = 8,
    parameter int T  = 3,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  in_a,
    input  logic [W-1:0]  in_b,
    input  logic          in_mode,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [W:0]    out_sum,
    output logic          out_err,
    input  logic          stat_clr,
    output logic [CW-1:0] txn_cnt,
    output logic [CW-1:0] err_cnt
);

    // The ripple over bits T..L-2 has width L-1-T. One extra bit holds the
    // carry out of that ripple.
    localparam int MW = L - T;
    localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};

    // Stage 1 registers
    logic          s1_valid_q;
    logic [W-1:0]  s1_a_q;
    logic [W-1:0]  s1_b_q;
    logic          s1_mode_q;

    // Stage 2 registers (these drive the outputs)
    logic          s2_valid_q;
    logic [W:0]    s2_sum_q;
    logic          s2_err_q;

    logic [CW-1:0] txn_q, txn_d;
    logic [CW-1:0] err_q, err_d;

    logic adv2, adv1;

    assign adv2     = !s2_valid_q | out_ready;
    assign adv1     = !s1_valid_q | adv2;
    assign in_ready = adv1;

    // ---------------- datapath between stage 1 and stage 2 ----------------
    logic [MW-1:0]  mid_sum;
    logic           ct, p, c, cout_lo;
    logic [MW-2:0]  low_mid;
    logic [L-1:0]   approx_lo;
    logic [W-L:0]   approx_hi;
    logic [W:0]     exact_sum;
    logic [W:0]     approx_sum;
    logic [W:0]     sum_d;
    logic           err_flag_d;

    assign mid_sum = {1'b0, s1_a_q[L-2:T]} + {1'b0, s1_b_q[L-2:T]};
    assign ct      = mid_sum[MW-1];
    assign p       = s1_a_q[L-1] ^ s1_b_q[L-1];
    // c: the top bit propagates and the ripple below it produced a carry.
    // The segment then overflows. The low bits collapse to zero and the
    // carry is passed upward.
    assign c       = p & ct;
    assign low_mid = mid_sum[MW-2:0] & {(MW-1){~c}};

    generate
        if (T > 0) begin : g_forced
            assign approx_lo = {ct | p, low_mid, {T{~c}}};
        end else begin : g_noforced
            assign approx_lo = {ct | p, low_mid};
        end
    endgenerate

    assign cout_lo    = (s1_a_q[L-1] & s1_b_q[L-1]) | c;
    assign approx_hi  = {1'b0, s1_a_q[W-1:L]} + {1'b0, s1_b_q[W-1:L]}
                      + {{(W-L){1'b0}}, cout_lo};
    assign approx_sum = {approx_hi, approx_lo};
    assign exact_sum  = {1'b0, s1_a_q} + {1'b0, s1_b_q};
    assign sum_d      = s1_mode_q ? exact_sum : approx_sum;
    assign err_flag_d = (sum_d != exact_sum);

    // ---------------- pipeline registers ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_a_q     <= '0;
            s1_b_q     <= '0;
            s1_mode_q  <= 1'b0;
        end else if (adv1) begin
            s1_valid_q <= in_valid;
            // Operands are captured only on an accepted transfer.
            if (in_valid) begin
                s1_a_q    <= in_a;
                s1_b_q    <= in_b;
                s1_mode_q <= in_mode;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid_q <= 1'b0;
            s2_sum_q   <= '0;
            s2_err_q   <= 1'b0;
        end else if (adv2) begin
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                s2_sum_q <= sum_d;
                s2_err_q <= err_flag_d;
            end
        end
    end

    // ---------------- statistics ----------------
    always_comb begin
        txn_d = txn_q;
        err_d = err_q;
        if (stat_clr) begin
            txn_d = '0;
            err_d = '0;
        end else if (s2_valid_q && out_ready) begin
            if (!(&txn_q)) txn_d = txn_q + CNT_ONE;
            if (s2_err_q && !(&err_q)) err_d = err_q + CNT_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            txn_q <= '0;
            err_q <= '0;
        end else begin
            txn_q <= txn_d;
            err_q <= err_d;
        end
    end

    assign out_valid = s2_valid_q;
    assign out_sum   = s2_sum_q;
    assign out_err   = s2_err_q;
    assign txn_cnt   = txn_q;
    assign err_cnt   = err_q;

endmodule
